// File: rtl/cgra_mem_bank_arbiter_pkg.sv
// Shared types and constants for the CGRA memory bank arbiter.
package cgra_mem_arb_pkg;

    localparam int unsigned MEM_DW  = 32;
    localparam int unsigned MEM_BEW = 4;

    typedef enum logic [1:0] {
        ACTIVE,
        RET,
        WAKE
    } arb_state_e;

    function automatic int unsigned next_rr_ptr(input int unsigned idx,
                                                input int unsigned num_ports);
        return (idx + 1 >= num_ports) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cgra_mem_bank_arbiter_if.sv
// Requester-side bus of the bank arbiter: one OBI-style request/response lane per port.
interface cgra_mem_bank_arbiter_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned NUM_WORDS = 1024
);
    import cgra_mem_arb_pkg::*;

    localparam int unsigned AddrWidth = $clog2(NUM_WORDS);

    logic [NUM_PORTS-1:0]                req;
    logic [NUM_PORTS-1:0]                we;
    logic [NUM_PORTS-1:0][AddrWidth-1:0] addr;
    logic [NUM_PORTS-1:0][MEM_DW-1:0]    wdata;
    logic [NUM_PORTS-1:0][MEM_BEW-1:0]   be;
    logic [NUM_PORTS-1:0]                gnt;
    logic [NUM_PORTS-1:0]                rvalid;
    logic [MEM_DW-1:0]                   rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/cgra_mem_bank_arbiter_rr_arbiter.sv
// Round-robin request picker; CGRA_MEM_ARB_FIXED_PRIO_EN switches to lowest-index-wins.
module cgra_rr_arbiter #(
    parameter int unsigned  NUM_PORTS = 4,
    localparam int unsigned IdxW      = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IdxW-1:0]      ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IdxW-1:0]      idx_o,
    output logic                 valid_o
);

    int unsigned cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
`ifdef CGRA_MEM_ARB_FIXED_PRIO_EN
            cand = i;
`else
            // Scan starts at the pointer and wraps past the last port.
            cand = 32'(ptr_i) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
`endif
            if (!valid_o && req_i[cand[IdxW-1:0]]) begin
                valid_o                  = 1'b1;
                idx_o                    = cand[IdxW-1:0];
                gnt_o[cand[IdxW-1:0]]    = 1'b1;
            end
        end
    end

`ifdef CGRA_MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
`endif

endmodule

// File: rtl/cgra_mem_bank_arbiter.sv
// Shares one single-port SRAM bank between NUM_PORTS requesters and sequences bank retention.
// Build option: CGRA_MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module cgra_mem_bank_arbiter
    import cgra_mem_arb_pkg::*;
#(
    parameter int unsigned  NUM_PORTS   = 4,
    parameter int unsigned  NUM_WORDS   = 1024,
    parameter int unsigned  WAKE_CYCLES = 2,
    localparam int unsigned AddrWidth   = $clog2(NUM_WORDS)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    cgra_mem_bank_arbiter_if.slave        bus_io,
    input  logic                          ret_req_i,
    output logic                          ret_ack_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [MEM_DW-1:0]             mem_wdata_o,
    output logic [MEM_BEW-1:0]            mem_be_o,
    output logic                          mem_set_retentive_no,
    input  logic [MEM_DW-1:0]             mem_rdata_i
);

    localparam int unsigned IdxW = $clog2(NUM_PORTS);
    localparam int unsigned CntW = $clog2(WAKE_CYCLES) + 1;

    arb_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      ptr_q;
    logic [NUM_PORTS-1:0] arb_gnt, gnt, rvalid_q;
    logic [IdxW-1:0]      arb_idx;
    logic                 arb_valid, arb_en, grant, wr_q;

    cgra_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .req_i   (bus_io.req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        arb_en               = 1'b0;
        ret_ack_o            = 1'b0;
        mem_set_retentive_no = 1'b1;
        unique case (state_q)
            ACTIVE: begin
                if (ret_req_i) begin
                    state_d = RET;
                end else begin
                    arb_en = 1'b1;
                end
            end
            RET: begin
                ret_ack_o            = 1'b1;
                mem_set_retentive_no = 1'b0;
                if (!ret_req_i) begin
                    state_d = WAKE;
                    cnt_d   = CntW'(WAKE_CYCLES - 1);
                end
            end
            WAKE: begin
                if (cnt_q == '0) begin
                    state_d = ACTIVE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    // Reset gates the combinational grant so nothing reaches the bank while held in reset.
    assign grant       = arb_en & arb_valid & rst_ni;
    assign gnt         = grant ? arb_gnt : '0;
    assign bus_io.gnt  = gnt;
    assign mem_req_o   = grant;
    assign mem_we_o    = grant & bus_io.we[arb_idx];
    assign mem_addr_o  = bus_io.addr[arb_idx];
    assign mem_wdata_o = bus_io.wdata[arb_idx];
    assign mem_be_o    = bus_io.be[arb_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ACTIVE;
            cnt_q    <= '0;
            rvalid_q <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt;
            wr_q     <= mem_we_o;
        end
    end

    assign bus_io.rvalid = rvalid_q;
    assign bus_io.rdata  = (|rvalid_q && !wr_q) ? mem_rdata_i : '0;

`ifdef CGRA_MEM_ARB_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    logic [IdxW-1:0] ptr_d;

    assign ptr_d = grant ? IdxW'(next_rr_ptr(32'(arb_idx), NUM_PORTS)) : ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_cgra_mem_bank_arbiter.sv
// Self-checking bench for cgra_mem_bank_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of arbitration, responses, retention and bank contents.
module tb_cgra_mem_bank_arbiter;

    localparam int NP = 4;
    localparam int NW = 1024;
    localparam int AW = 10;
    localparam int WK = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cgra_mem_bank_arbiter_if #(.NUM_PORTS(NP), .NUM_WORDS(NW)) bus ();

    logic          ret_req, ret_ack, mem_req, mem_we, mem_retn;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_be;

    cgra_mem_bank_arbiter #(
        .NUM_PORTS   (NP),
        .NUM_WORDS   (NW),
        .WAKE_CYCLES (WK)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .bus_io               (bus),
        .ret_req_i            (ret_req),
        .ret_ack_o            (ret_ack),
        .mem_req_o            (mem_req),
        .mem_we_o             (mem_we),
        .mem_addr_o           (mem_addr),
        .mem_wdata_o          (mem_wdata),
        .mem_be_o             (mem_be),
        .mem_set_retentive_no (mem_retn),
        .mem_rdata_i          (mem_rdata)
    );

    // SRAM environment: single port, one-cycle read latency, byte-enabled writes.
    logic [31:0]   sram [NW];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;
    always @(posedge clk) begin
        if (pl_en) begin
            sram[pl_addr] <= pl_data;
        end else if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus
    logic [NP-1:0] t_req, t_we;
    logic [AW-1:0] t_addr [NP];
    logic [31:0]   t_wdata [NP];
    logic [3:0]    t_be [NP];
    logic          t_ret;

    // Reference model: mode 0 active, 1 retention, 2 waking
    logic [31:0]   shadow [NW];
    int            m_mode, m_wake_left, m_ptr, m_pp;
    bit            m_pv;
    logic [31:0]   m_prd;
    int            e_idx;
    logic [NP-1:0] e_gnt, e_rvalid;
    logic [31:0]   e_rdata;
    logic          e_ack, e_retn;

    task automatic model_reset();
        m_mode = 0; m_wake_left = 0; m_ptr = 0; m_pv = 0; m_pp = 0; m_prd = 0;
    endtask

    task automatic model_eval();
        e_idx = -1;
        e_gnt = '0;
        if (m_mode == 0 && !t_ret) begin
            for (int i = 0; i < NP; i++) begin
                int p;
`ifdef CGRA_MEM_ARB_FIXED_PRIO_EN
                p = i;
`else
                p = (m_ptr + i) % NP;
`endif
                if (e_idx < 0 && t_req[p]) e_idx = p;
            end
        end
        if (e_idx >= 0) e_gnt[e_idx] = 1'b1;
        e_rvalid = m_pv ? (NP'(1) << m_pp) : '0;
        e_rdata  = m_pv ? m_prd : 32'h0;
        e_ack    = (m_mode == 1);
        e_retn   = (m_mode != 1);
    endtask

    task automatic model_advance();
        m_pv = (e_idx >= 0);
        if (m_pv) begin
            m_pp = e_idx;
            if (t_we[e_idx]) begin
                m_prd = 32'h0;
                for (int b = 0; b < 4; b++)
                    if (t_be[e_idx][b])
                        shadow[t_addr[e_idx]][8*b +: 8] = t_wdata[e_idx][8*b +: 8];
            end else begin
                m_prd = shadow[t_addr[e_idx]];
            end
            m_ptr = (e_idx + 1) % NP;
        end
        case (m_mode)
            0: if (t_ret) m_mode = 1;
            1: if (!t_ret) begin m_mode = 2; m_wake_left = WK; end
            default: begin
                m_wake_left--;
                if (m_wake_left == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic apply();
        bus.req = t_req;
        bus.we  = t_we;
        for (int i = 0; i < NP; i++) begin
            bus.addr[i]  = t_addr[i];
            bus.wdata[i] = t_wdata[i];
            bus.be[i]    = t_be[i];
        end
        ret_req = t_ret;
        model_eval();
    endtask

    task automatic cycle_begin();
        @(negedge clk);
        apply();
        #1;
    endtask

    task automatic idle_inputs();
        t_req = '0; t_we = '0; t_ret = 1'b0;
        for (int i = 0; i < NP; i++) begin
            t_addr[i] = '0; t_wdata[i] = '0; t_be[i] = 4'hf;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        apply();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        t_req = '1;
        apply();
        #3;
        n_tests++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL rst_gnt got %b want 0", bus.gnt); end
        n_tests++; if (bus.rvalid !== '0) begin n_fail++; $display("FAIL rst_rvalid got %b want 0", bus.rvalid); end
        n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
        n_tests++; if (ret_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b want 0", ret_ack); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_memreq got %b want 0", mem_req); end
        n_tests++; if (mem_retn !== 1'b1) begin n_fail++; $display("FAIL rst_retn got %b want 1", mem_retn); end
        // Preload the low words while the arbiter is held in reset.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = AW'(i);
            pl_data = (i == 16) ? 32'hDEADBEEF : $urandom;
            shadow[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
        n_tests++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL rst_hold_gnt got %b want 0", bus.gnt); end
        idle_inputs();
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_read();
        idle_inputs();
        t_req[2] = 1'b1; t_addr[2] = AW'(16);
        cycle_begin();
        n_tests++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL rd_gnt got %b want 0100", bus.gnt); end
        n_tests++; if (mem_addr !== AW'(16) || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL rd_mem got addr %h we %b want 010 0", mem_addr, mem_we); end
        model_advance();
        t_req = '0;
        cycle_begin();
        n_tests++; if (bus.rvalid !== 4'b0100) begin n_fail++; $display("FAIL rd_rvalid got %b want 0100", bus.rvalid); end
        n_tests++; if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", bus.rdata); end
        model_advance();
    endtask

    task automatic test_contention();
        logic [NP-1:0] want;
        do_reset();
        idle_inputs();
        t_req = '1;
        for (int i = 0; i < NP; i++) t_addr[i] = AW'(i + 1);
        for (int c = 0; c < 6; c++) begin
            if (c == 5) t_req = '0;
            cycle_begin();
`ifdef CGRA_MEM_ARB_FIXED_PRIO_EN
            want = (c < 5) ? 4'b0001 : 4'b0000;
`else
            want = (c < 5) ? (NP'(1) << (c % NP)) : 4'b0000;
`endif
            n_tests++; if (bus.gnt !== want) begin n_fail++; $display("FAIL cont_gnt cyc %0d got %b want %b", c, bus.gnt, want); end
            n_tests++; if (bus.rvalid !== e_rvalid || bus.rdata !== e_rdata) begin
                n_fail++; $display("FAIL cont_rsp cyc %0d got %b/%h want %b/%h", c, bus.rvalid, bus.rdata, e_rvalid, e_rdata); end
            model_advance();
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] prior;
        prior = shadow[5];
        idle_inputs();
        t_req[1] = 1'b1; t_we[1] = 1'b1; t_addr[1] = AW'(5);
        t_wdata[1] = 32'hAABBCCDD; t_be[1] = 4'b0011;
        cycle_begin();
        n_tests++; if (bus.gnt !== 4'b0010 || mem_be !== 4'b0011 || mem_we !== 1'b1) begin
            n_fail++; $display("FAIL bw_gnt got %b be %b we %b want 0010 0011 1", bus.gnt, mem_be, mem_we); end
        model_advance();
        idle_inputs();
        t_req[0] = 1'b1; t_addr[0] = AW'(5);
        cycle_begin();
        n_tests++; if (bus.rvalid !== 4'b0010 || bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL bw_wrsp got %b/%h want 0010/0", bus.rvalid, bus.rdata); end
        model_advance();
        t_req = '0;
        cycle_begin();
        n_tests++; if (bus.rvalid !== 4'b0001 || bus.rdata !== {prior[31:16], 16'hCCDD}) begin
            n_fail++; $display("FAIL bw_rd got %b/%h want 0001/%h", bus.rvalid, bus.rdata, {prior[31:16], 16'hCCDD}); end
        model_advance();
    endtask

    task automatic test_retention();
        int wake_free;
        bit seen;
        idle_inputs();
        t_req[3] = 1'b1; t_addr[3] = AW'(3);
        cycle_begin();
        n_tests++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL ret_g3 got %b want 1000", bus.gnt); end
        model_advance();
        t_req = '1; t_ret = 1'b1;
        for (int i = 0; i < NP; i++) t_addr[i] = AW'(3 + 4 * i);
        cycle_begin();
        n_tests++; if (bus.gnt !== '0 || bus.rvalid !== 4'b1000 || bus.rdata !== shadow[3]) begin
            n_fail++; $display("FAIL ret_last got %b %b/%h want 0000 1000/%h", bus.gnt, bus.rvalid, bus.rdata, shadow[3]); end
        model_advance();
        for (int c = 0; c < 4; c++) begin
            cycle_begin();
            n_tests++; if (ret_ack !== 1'b1 || mem_retn !== 1'b0 || bus.gnt !== '0 || mem_req !== 1'b0) begin
                n_fail++; $display("FAIL ret_hold cyc %0d got ack %b retn %b gnt %b req %b want 1 0 0000 0",
                                   c, ret_ack, mem_retn, bus.gnt, mem_req); end
            model_advance();
        end
        t_ret = 1'b0;
        cycle_begin();
        n_tests++; if (ret_ack !== 1'b1 || bus.gnt !== '0) begin
            n_fail++; $display("FAIL ret_drop got ack %b gnt %b want 1 0000", ret_ack, bus.gnt); end
        model_advance();
        wake_free = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            t_ret = (c == 0);  // pulse during waking must be ignored
            cycle_begin();
            n_tests++; if (bus.gnt !== e_gnt || ret_ack !== e_ack || mem_retn !== e_retn) begin
                n_fail++; $display("FAIL wake cyc %0d got gnt %b ack %b retn %b want %b %b %b",
                                   c, bus.gnt, ret_ack, mem_retn, e_gnt, e_ack, e_retn); end
            if (bus.gnt !== '0) seen = 1; else wake_free++;
            model_advance();
        end
        n_tests++; if (!seen || wake_free != WK) begin
            n_fail++; $display("FAIL wake_len got %0d grant-free cycles (resumed %0d) want %0d", wake_free, seen, WK); end
        t_req = '0; t_ret = 1'b0;
        cycle_begin();
        n_tests++; if (bus.rvalid !== e_rvalid || bus.rdata !== e_rdata) begin
            n_fail++; $display("FAIL ret_data got %b/%h want %b/%h", bus.rvalid, bus.rdata, e_rvalid, e_rdata); end
        model_advance();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!t_req[i] && $urandom_range(0, 1) == 1) begin
                    t_req[i]   = 1'b1;
                    t_we[i]    = 1'($urandom_range(0, 1));
                    t_addr[i]  = AW'($urandom_range(0, 31));
                    t_wdata[i] = $urandom;
                    t_be[i]    = 4'($urandom_range(0, 15));
                end else if (t_req[i] && $urandom_range(0, 15) == 0) begin
                    t_req[i] = 1'b0;  // withdrawn without a grant
                end
            end
            if (c >= 390) t_ret = 1'b0;
            else if ($urandom_range(0, 11) == 0) t_ret = ~t_ret;
            cycle_begin();
            n_tests++; if (bus.gnt !== e_gnt || mem_req !== (|e_gnt)) begin
                n_fail++; $display("FAIL rnd_gnt cyc %0d got %b/%b want %b", c, bus.gnt, mem_req, e_gnt); end
            n_tests++; if (bus.rvalid !== e_rvalid || bus.rdata !== e_rdata) begin
                n_fail++; $display("FAIL rnd_rsp cyc %0d got %b/%h want %b/%h", c, bus.rvalid, bus.rdata, e_rvalid, e_rdata); end
            n_tests++; if (ret_ack !== e_ack || mem_retn !== e_retn) begin
                n_fail++; $display("FAIL rnd_ret cyc %0d got %b/%b want %b/%b", c, ret_ack, mem_retn, e_ack, e_retn); end
            if (e_idx >= 0) begin
                n_tests++;
                if ({mem_we, mem_addr, mem_wdata, mem_be} !==
                    {t_we[e_idx], t_addr[e_idx], t_wdata[e_idx], t_be[e_idx]}) begin
                    n_fail++; $display("FAIL rnd_mem cyc %0d got %b %h %h %b want %b %h %h %b", c, mem_we, mem_addr,
                                       mem_wdata, mem_be, t_we[e_idx], t_addr[e_idx], t_wdata[e_idx], t_be[e_idx]); end
            end
            model_advance();
            for (int i = 0; i < NP; i++) if (e_gnt[i]) t_req[i] = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        t_ret = 1'b1;
        cycle_begin(); model_advance();
        cycle_begin();
        n_tests++; if (mem_retn !== 1'b0) begin n_fail++; $display("FAIL ar_inret got %b want 0", mem_retn); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (mem_retn !== 1'b1 || ret_ack !== 1'b0) begin
            n_fail++; $display("FAIL ar_retn got %b ack %b want 1 0", mem_retn, ret_ack); end
        model_reset();
        idle_inputs();
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        t_req[0] = 1'b1; t_addr[0] = AW'(7);
        cycle_begin();
        n_tests++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL ar_g0 got %b want 0001", bus.gnt); end
        model_advance();
        @(posedge clk);
        #2;
        n_tests++; if (bus.rvalid !== 4'b0001) begin n_fail++; $display("FAIL ar_pend got %b want 0001", bus.rvalid); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.rvalid !== '0 || bus.gnt !== '0 || mem_req !== 1'b0 || mem_retn !== 1'b1) begin
            n_fail++; $display("FAIL ar_mid got rv %b gnt %b req %b retn %b want 0 0 0 1",
                               bus.rvalid, bus.gnt, mem_req, mem_retn); end
        t_req = '1;
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL ar_ptr0 got %b want 0001", bus.gnt); end
        idle_inputs();
        apply();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_byte_write();
        test_retention();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
